// File: rtl/vec_issue_seq_if.sv
// Command, vector-memory and execute-unit signals of the vec_issue_seq sequencer.
// The master side is the sequencer. The slave side is the surrounding datapath.
interface vec_issue_seq_if #(
  parameter int AW = 8,
  parameter int LW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_opcode;
  logic [AW-1:0] cmd_src_a;
  logic [AW-1:0] cmd_src_b;
  logic [AW-1:0] cmd_dst;
  logic [LW-1:0] cmd_len;
  logic          rd_en;
  logic [AW-1:0] rd_a_addr;
  logic [AW-1:0] rd_b_addr;
  logic [63:0]   rd_a_data;
  logic [63:0]   rd_b_data;
  logic [3:0]    ex_opcode;
  logic [63:0]   ex_a;
  logic [63:0]   ex_b;
  logic [63:0]   ex_result;
  logic          wr_en;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [63:0]   wr_data;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    input  cmd_valid, cmd_opcode, cmd_src_a, cmd_src_b, cmd_dst, cmd_len,
    input  rd_a_data, rd_b_data, ex_result, wr_ready,
    output cmd_ready, rd_en, rd_a_addr, rd_b_addr, ex_opcode, ex_a, ex_b,
    output wr_en, wr_addr, wr_data, busy, done, err
  );

  modport slave (
    output cmd_valid, cmd_opcode, cmd_src_a, cmd_src_b, cmd_dst, cmd_len,
    output rd_a_data, rd_b_data, ex_result, wr_ready,
    input  cmd_ready, rd_en, rd_a_addr, rd_b_addr, ex_opcode, ex_a, ex_b,
    input  wr_en, wr_addr, wr_data, busy, done, err
  );
endinterface

// File: rtl/vec_issue_seq.sv
// Sequencer that streams one vector command through the int16x4 execute unit:
// read both operands, register them, write the result, then signal done.
module vec_issue_seq #(
  parameter int AW = 8,
  parameter int LW = 8
) (
  input  logic           clk,
  input  logic           rst,
  vec_issue_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal;
    case (op)
      4'h0:    legal = 1'b1;
      4'h1:    legal = 1'b1;
      4'h4:    legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_a_q, ptr_a_d;
  logic [AW-1:0] ptr_b_q, ptr_b_d;
  logic [AW-1:0] ptr_dst_q, ptr_dst_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [3:0]    opcode_q, opcode_d;
  logic          err_flag_q, err_flag_d;
  logic [63:0]   ex_a_q, ex_a_d;
  logic [63:0]   ex_b_q, ex_b_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          rd_en_q, rd_en_d;
  logic          wr_en_q, wr_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  // Next-state, datapath capture and registered-output decode.
  always_comb begin
    state_d    = state_q;
    ptr_a_d    = ptr_a_q;
    ptr_b_d    = ptr_b_q;
    ptr_dst_d  = ptr_dst_q;
    cnt_d      = cnt_q;
    opcode_d   = opcode_q;
    err_flag_d = err_flag_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          opcode_d  = bus.cmd_opcode;
          ptr_a_d   = bus.cmd_src_a;
          ptr_b_d   = bus.cmd_src_b;
          ptr_dst_d = bus.cmd_dst;
          cnt_d     = bus.cmd_len;
          if (!is_legal_op(bus.cmd_opcode)) begin
            err_flag_d = 1'b1;
            state_d    = S_DONE;
          end else if (bus.cmd_len == LW'(0)) begin
            err_flag_d = 1'b0;
            state_d    = S_DONE;
          end else begin
            err_flag_d = 1'b0;
            state_d    = S_READ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        ex_a_d  = bus.rd_a_data;
        ex_b_d  = bus.rd_b_data;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        // Pointers only move once the write is taken, so addr/data hold during a stall.
        if (bus.wr_ready) begin
          ptr_a_d   = ptr_a_q + AW'(1);
          ptr_b_d   = ptr_b_q + AW'(1);
          ptr_dst_d = ptr_dst_q + AW'(1);
          cnt_d     = cnt_q - LW'(1);
          if (cnt_q == LW'(1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
          end
        end else begin
          state_d = S_WRITE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    rd_en_d     = (state_d == S_READ);
    wr_en_d     = (state_d == S_WRITE);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_DONE) && err_flag_d;
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_a_q     <= '0;
      ptr_b_q     <= '0;
      ptr_dst_q   <= '0;
      cnt_q       <= '0;
      opcode_q    <= 4'h0;
      err_flag_q  <= 1'b0;
      ex_a_q      <= 64'h0;
      ex_b_q      <= 64'h0;
      cmd_ready_q <= 1'b1;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_a_q     <= ptr_a_d;
      ptr_b_q     <= ptr_b_d;
      ptr_dst_q   <= ptr_dst_d;
      cnt_q       <= cnt_d;
      opcode_q    <= opcode_d;
      err_flag_q  <= err_flag_d;
      ex_a_q      <= ex_a_d;
      ex_b_q      <= ex_b_d;
      cmd_ready_q <= cmd_ready_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_a_addr = ptr_a_q;
  assign bus.rd_b_addr = ptr_b_q;
  assign bus.ex_opcode = opcode_q;
  assign bus.ex_a      = ex_a_q;
  assign bus.ex_b      = ex_b_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = ptr_dst_q;
  assign bus.wr_data   = bus.ex_result;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule
